// File: rtl/store_buf_mod_pkg.sv
// Shared store-path definitions: funct3 store codes, dmem address width, byte-strobe
// constants and the store formatter used by the top level.
package store_buf_mod_pkg;

    localparam logic [2:0] FUNC3_SB = 3'b000;
    localparam logic [2:0] FUNC3_SH = 3'b001;
    localparam logic [2:0] FUNC3_SW = 3'b010;

    localparam int DMEM_AW = 11;

    localparam logic [3:0] STRB_NONE    = 4'b0000;
    localparam logic [3:0] STRB_BYTE    = 4'b0001;
    localparam logic [3:0] STRB_HALF_LO = 4'b0011;
    localparam logic [3:0] STRB_HALF_HI = 4'b1100;
    localparam logic [3:0] STRB_WORD    = 4'b1111;

    typedef struct packed {
        logic        legal;
        logic [31:0] data;
        logic [3:0]  strb;
    } st_fmt_t;

    // Replicates the source lanes so memory only needs the strobes to pick the target bytes.
    function automatic st_fmt_t format_store(input logic [2:0]  funct3,
                                             input logic [1:0]  lane,
                                             input logic [31:0] d);
        st_fmt_t f;
        f = '{legal: 1'b0, data: 32'h0, strb: STRB_NONE};
        case (funct3)
            FUNC3_SB: begin
                f.legal = 1'b1;
                f.data  = {4{d[7:0]}};
                f.strb  = STRB_BYTE << lane;
            end
            FUNC3_SH: begin
                f.legal = ~lane[0];
                f.data  = {2{d[15:0]}};
                f.strb  = lane[1] ? STRB_HALF_HI : STRB_HALF_LO;
            end
            FUNC3_SW: begin
                f.legal = (lane == 2'b00);
                f.data  = d;
                f.strb  = STRB_WORD;
            end
            default: ;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/store_buf_mod_st_fifo.sv
// Store queue: DEPTH entries of {word address, data, strobes} with count/pointers and an
// occupancy vector so the top can compare queued addresses against loads.
module store_buf_mod_st_fifo #(
    parameter int DEPTH = 4,
    parameter int WAW   = 9,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WAW-1:0]   push_waddr,
    input  logic [31:0]      push_data,
    input  logic [3:0]       push_strb,
    input  logic             pop,
    output logic [WAW-1:0]   head_waddr,
    output logic [31:0]      head_data,
    output logic [3:0]       head_strb,
    output logic [WAW-1:0]   entry_waddr [DEPTH],
    output logic [DEPTH-1:0] occ,
    output logic [CW-1:0]    count
);

    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d;
    logic [WAW-1:0] waddr_q [DEPTH];
    logic [WAW-1:0] waddr_d [DEPTH];
    logic [31:0]    data_q  [DEPTH];
    logic [31:0]    data_d  [DEPTH];
    logic [3:0]     strb_q  [DEPTH];
    logic [3:0]     strb_d  [DEPTH];

    always_comb begin
        // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        waddr_d  = waddr_q;
        data_d   = data_q;
        strb_d   = strb_q;
        if (push) begin
            waddr_d[wr_ptr_q] = push_waddr;
            data_d[wr_ptr_q]  = push_data;
            strb_d[wr_ptr_q]  = push_strb;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: ;
        endcase
    end

    // NOTE: sequential state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: payload storage is deliberately not reset; occupancy qualifies every use of it.
    always_ff @(posedge clk) begin
        waddr_q <= waddr_d;
        data_q  <= data_d;
        strb_q  <= strb_d;
    end

    // An entry is live when its distance from the read pointer is below the count.
    always_comb begin
        occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occ[i] = ({1'b0, PW'(i) - rd_ptr_q} < count_q);
        end
    end

    assign head_waddr  = waddr_q[rd_ptr_q];
    assign head_data   = data_q[rd_ptr_q];
    assign head_strb   = strb_q[rd_ptr_q];
    assign entry_waddr = waddr_q;
    assign count       = count_q;

endmodule

// File: rtl/store_buf_mod.sv
// Store path to data memory: formats SB/SH/SW into lane-aligned data + strobes, queues them,
// drains over valid/ready and flags loads that hit a queued word.
module store_buf_mod
    import store_buf_mod_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = DMEM_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          stall,
    input  logic          st_valid,
    input  logic [2:0]    inst_funct3,
    input  logic [31:0]   st_addr,
    input  logic [31:0]   st_data,
    output logic          st_ready,
    output logic          st_err,
    input  logic          ld_valid,
    input  logic [31:0]   ld_addr,
    output logic          ld_hazard,
    output logic          mem_wvalid,
    input  logic          mem_ready,
    output logic [AW-1:0] mem_waddr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb
);

    localparam int WAW = AW - 2;
    localparam int CW  = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    st_fmt_t          fmt;
    logic             push, pop;
    logic [CW-1:0]    count;
    logic [WAW-1:0]   head_waddr;
    logic [31:0]      head_data;
    logic [3:0]       head_strb;
    logic [WAW-1:0]   entry_waddr [DEPTH];
    logic [DEPTH-1:0] occ;
    logic             st_err_q, st_err_d;
    logic             unused_addr_bits;

    assign fmt = format_store(inst_funct3, st_addr[1:0], st_data);

    // Readiness looks at count only, so a full queue never accepts even while popping.
    assign st_ready   = (count < DEPTH_C);
    assign push       = st_valid & ~stall & st_ready & fmt.legal;
    assign st_err_d   = st_valid & ~fmt.legal;
    assign mem_wvalid = (count != '0);
    assign pop        = mem_wvalid & mem_ready;

    store_buf_mod_st_fifo #(
        .DEPTH (DEPTH),
        .WAW   (WAW)
    ) u_st_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_waddr  (st_addr[AW-1:2]),
        .push_data   (fmt.data),
        .push_strb   (fmt.strb),
        .pop         (pop),
        .head_waddr  (head_waddr),
        .head_data   (head_data),
        .head_strb   (head_strb),
        .entry_waddr (entry_waddr),
        .occ         (occ),
        .count       (count)
    );

    // Payload is forced to zero when nothing is queued so reset and idle outputs are clean.
    assign mem_waddr = mem_wvalid ? {head_waddr, 2'b00} : '0;
    assign mem_wdata = mem_wvalid ? head_data : '0;
    assign mem_wstrb = mem_wvalid ? head_strb : '0;

    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (occ[i] && (entry_waddr[i] == ld_addr[AW-1:2])) begin
                ld_hazard = 1'b1;
            end
        end
        ld_hazard = ld_hazard & ld_valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_err_q <= 1'b0;
        end else begin
            st_err_q <= st_err_d;
        end
    end

    assign st_err = st_err_q;

    // Address bits beyond the dmem window and the load byte offset take no part in the logic.
    assign unused_addr_bits = ^{st_addr[31:AW], ld_addr[31:AW], ld_addr[1:0]};

endmodule

// File: tb/tb_store_buf_mod.sv
// Directed bench for store_buf_mod: stimulus pushes expected memory writes into a scoreboard
// queue, and an independent monitor pops and compares on every accepted drain beat.
module tb_store_buf_mod;
    import store_buf_mod_pkg::*;

    localparam int DEPTH = 4;
    localparam int AW    = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          stall;
    logic          st_valid;
    logic [2:0]    inst_funct3;
    logic [31:0]   st_addr;
    logic [31:0]   st_data;
    logic          st_ready;
    logic          st_err;
    logic          ld_valid;
    logic [31:0]   ld_addr;
    logic          ld_hazard;
    logic          mem_wvalid;
    logic          mem_ready;
    logic [AW-1:0] mem_waddr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;

    always #5 clk = ~clk;

    store_buf_mod #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .st_valid    (st_valid),
        .inst_funct3 (inst_funct3),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_ready    (st_ready),
        .st_err      (st_err),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_hazard   (ld_hazard),
        .mem_wvalid  (mem_wvalid),
        .mem_ready   (mem_ready),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_wstrb   (mem_wstrb)
    );

    typedef struct {
        logic [AW-1:0] waddr;
        logic [31:0]   data;
        logic [3:0]    strb;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Drives one store for a single cycle; the expected memory write is queued when it should be accepted.
    task automatic store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d,
                         input bit exp_push, input logic [AW-1:0] ewaddr,
                         input logic [31:0] ewdata, input logic [3:0] ewstrb);
        st_valid    = 1'b1;
        inst_funct3 = f3;
        st_addr     = a;
        st_data     = d;
        if (exp_push) exp_q.push_back('{waddr: ewaddr, data: ewdata, strb: ewstrb});
        @(posedge clk);
        #1;
        st_valid = 1'b0;
    endtask

    // Monitor: compares each accepted drain beat and checks the head holds while stalled by memory.
    logic          hold;
    logic [AW-1:0] hold_waddr;
    logic [31:0]   hold_wdata;
    logic [3:0]    hold_wstrb;
    initial hold = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_waddr", 32'(mem_waddr), 32'(hold_waddr));
                check("hold_wdata", mem_wdata, hold_wdata);
                check("hold_wstrb", 32'(mem_wstrb), 32'(hold_wstrb));
            end
            if (mem_wvalid && mem_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL drain_unexpected: got waddr %h, required no pending write", mem_waddr);
                end else begin
                    e = exp_q.pop_front();
                    check("drain_waddr", 32'(mem_waddr), 32'(e.waddr));
                    check("drain_wdata", mem_wdata, e.data);
                    check("drain_wstrb", 32'(mem_wstrb), 32'(e.strb));
                end
            end
            hold       = mem_wvalid && !mem_ready;
            hold_waddr = mem_waddr;
            hold_wdata = mem_wdata;
            hold_wstrb = mem_wstrb;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1; stall = 1'b0; st_valid = 1'b0; inst_funct3 = 3'b000;
        st_addr = '0; st_data = '0; ld_valid = 1'b0; ld_addr = '0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        ld_valid = 1'b1;
        ld_addr  = 32'h0;
        @(negedge clk);
        check("rst_st_ready",   32'(st_ready),   32'd1);
        check("rst_mem_wvalid", 32'(mem_wvalid), 32'd0);
        check("rst_st_err",     32'(st_err),     32'd0);
        check("rst_ld_hazard",  32'(ld_hazard),  32'd0);
        check("rst_mem_waddr",  32'(mem_waddr),  32'd0);
        check("rst_mem_wdata",  mem_wdata,       32'd0);
        check("rst_mem_wstrb",  32'(mem_wstrb),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0; ld_valid = 1'b0; mem_ready = 1'b1;

        // Single SW: visible the cycle after the push, gone after one accepted beat.
        store(FUNC3_SW, 32'h10, 32'hDEADBEEF, 1, 11'h10, 32'hDEADBEEF, 4'b1111);
        @(negedge clk);
        check("sw_latency_wvalid", 32'(mem_wvalid), 32'd1);
        @(negedge clk);
        check("sw_popped_wvalid", 32'(mem_wvalid), 32'd0);

        // Byte and halfword lane formatting, back to back.
        store(FUNC3_SB, 32'h23, 32'h000000A5, 1, 11'h20, 32'hA5A5A5A5, 4'b1000);
        store(FUNC3_SH, 32'h42, 32'h00001234, 1, 11'h40, 32'h12341234, 4'b1100);
        repeat (2) @(negedge clk);
        check("sb_sh_drained", 32'(mem_wvalid), 32'd0);

        // Misaligned stores are dropped with a one-cycle error pulse.
        store(FUNC3_SH, 32'h41, 32'h0000FFFF, 0, '0, '0, '0);
        @(negedge clk);
        check("sh_mis_err",    32'(st_err),     32'd1);
        check("sh_mis_nopush", 32'(mem_wvalid), 32'd0);
        @(negedge clk);
        check("sh_mis_err_end", 32'(st_err), 32'd0);
        store(FUNC3_SW, 32'h42, 32'h12345678, 0, '0, '0, '0);
        @(negedge clk);
        check("sw_mis_err",      32'(st_err),     32'd1);
        check("sw_mis_nopush",   32'(mem_wvalid), 32'd0);
        check("sw_mis_st_ready", 32'(st_ready),   32'd1);
        @(negedge clk);
        check("sw_mis_err_end", 32'(st_err), 32'd0);

        // Fill the queue with memory stalled, reject a fifth store, then drain in order.
        mem_ready = 1'b0;
        store(FUNC3_SB, 32'h101, 32'h00000077, 1, 11'h100, 32'h77777777, 4'b0010);
        store(FUNC3_SH, 32'h106, 32'h0000BEEF, 1, 11'h104, 32'hBEEFBEEF, 4'b1100);
        store(FUNC3_SW, 32'h108, 32'hCAFEF00D, 1, 11'h108, 32'hCAFEF00D, 4'b1111);
        store(FUNC3_SW, 32'h10C, 32'h01234567, 1, 11'h10C, 32'h01234567, 4'b1111);
        @(negedge clk);
        check("full_st_ready", 32'(st_ready),   32'd0);
        check("full_wvalid",   32'(mem_wvalid), 32'd1);
        store(FUNC3_SW, 32'h200, 32'h55555555, 0, '0, '0, '0);
        @(negedge clk);
        check("full_legal_no_err", 32'(st_err),   32'd0);
        check("full_still_full",   32'(st_ready), 32'd0);
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("st_ready_after_pop", 32'(st_ready), 32'd1);
        repeat (3) @(negedge clk);
        check("drain_all_wvalid",   32'(mem_wvalid), 32'd0);
        check("drain_all_st_ready", 32'(st_ready),   32'd1);

        // Load hazard against a queued word.
        mem_ready = 1'b0;
        store(FUNC3_SW, 32'h80, 32'h00000011, 1, 11'h080, 32'h00000011, 4'b1111);
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = 32'h83;
        #1 check("hazard_same_word", 32'(ld_hazard), 32'd1);
        ld_addr = 32'h84;
        #1 check("hazard_next_word", 32'(ld_hazard), 32'd0);
        ld_addr = 32'h883;
        #1 check("hazard_high_bits", 32'(ld_hazard), 32'd1);
        ld_valid = 1'b0; ld_addr = 32'h80;
        #1 check("hazard_no_load", 32'(ld_hazard), 32'd0);
        ld_valid = 1'b1;
        @(posedge clk);
        #1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("hazard_popping", 32'(ld_hazard), 32'd1);
        @(negedge clk);
        check("hazard_after_pop", 32'(ld_hazard), 32'd0);
        ld_valid = 1'b0;

        // Stall blocks the push but not the error pulse.
        stall = 1'b1;
        store(FUNC3_SW, 32'h90, 32'h99999999, 0, '0, '0, '0);
        @(negedge clk);
        check("stall_nopush", 32'(mem_wvalid), 32'd0);
        check("stall_no_err", 32'(st_err),     32'd0);
        store(FUNC3_SW, 32'h91, 32'h0, 0, '0, '0, '0);
        @(negedge clk);
        check("stall_illegal_err", 32'(st_err), 32'd1);
        stall = 1'b0;

        // Streaming stores with concurrent push and pop.
        store(FUNC3_SW, 32'hA0, 32'h00000001, 1, 11'h0A0, 32'h00000001, 4'b1111);
        store(FUNC3_SW, 32'hA4, 32'h00000002, 1, 11'h0A4, 32'h00000002, 4'b1111);
        store(FUNC3_SB, 32'hA9, 32'h0000003C, 1, 11'h0A8, 32'h3C3C3C3C, 4'b0010);
        repeat (2) @(negedge clk);
        check("stream_drained", 32'(mem_wvalid), 32'd0);

        // Reset with entries queued discards them.
        mem_ready = 1'b0;
        store(FUNC3_SW, 32'hC0, 32'h000000C0, 1, 11'h0C0, 32'h000000C0, 4'b1111);
        store(FUNC3_SW, 32'hC4, 32'h000000C4, 1, 11'h0C4, 32'h000000C4, 4'b1111);
        store(FUNC3_SW, 32'hC8, 32'h000000C8, 1, 11'h0C8, 32'h000000C8, 4'b1111);
        @(negedge clk);
        check("pre_rst_wvalid", 32'(mem_wvalid), 32'd1);
        rst = 1'b1;
        exp_q.delete();
        ld_valid = 1'b1; ld_addr = 32'hC0;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("mid_rst_wvalid",   32'(mem_wvalid), 32'd0);
        check("mid_rst_st_ready", 32'(st_ready),   32'd1);
        check("mid_rst_hazard",   32'(ld_hazard),  32'd0);
        rst = 1'b0; ld_valid = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_empty", 32'(mem_wvalid), 32'd0);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
